// File: rtl/gated_pulse_counter.sv
// Gated pulse counter: picks one of two pulse/enable sources, synchronizes it, samples on a
// 4 MHz strobe derived from clk_12mhz and splits rising edges into enabled / disabled totals.
module gated_pulse_counter (
    input  logic        clk_12mhz,
    input  logic        reset,
    input  logic        cnt_choise,
    input  logic        count1,
    input  logic        enable1,
    input  logic        count2,
    input  logic        enable2,
    output logic        clk_4mhz,
    output logic [23:0] count_p,
    output logic [23:0] count_m
);

    logic [1:0] div;
    logic       cnt_in, cnt_en;
    logic [1:0] sync_cnt, sync_en, sync_sel;
    logic       s_cnt, s_sel;
    logic       sel_change, rise, inc_p, inc_m;

    // Divide-by-3 strobe; registered so it is high on the cycle after div reaches 2.
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            div      <= 2'd0;
            clk_4mhz <= 1'b0;
        end else begin
            div      <= (div == 2'd2) ? 2'd0 : div + 2'd1;
            clk_4mhz <= (div == 2'd2);
        end
    end

    always_comb begin
        cnt_in = cnt_choise ? count2  : count1;
        cnt_en = cnt_choise ? enable2 : enable1;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            sync_cnt <= 2'b00;
            sync_en  <= 2'b00;
            sync_sel <= 2'b00;
        end else begin
            sync_cnt <= {sync_cnt[0], cnt_in};
            sync_en  <= {sync_en[0],  cnt_en};
            sync_sel <= {sync_sel[0], cnt_choise};
        end
    end

    // s_cnt holds the count level seen at the previous strobe; a source change blocks one strobe.
    always_comb begin
        sel_change = sync_sel[1] != s_sel;
        rise       = !sel_change && sync_cnt[1] && !s_cnt;
        inc_p      = clk_4mhz && rise && sync_en[1];
        inc_m      = clk_4mhz && rise && !sync_en[1];
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            s_cnt <= 1'b0;
            s_sel <= 1'b0;
        end else if (clk_4mhz) begin
            s_cnt <= sync_cnt[1];
            s_sel <= sync_sel[1];
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            count_p <= 24'd0;
            count_m <= 24'd0;
        end else begin
            if (inc_p && count_p != 24'hFFFFFF) count_p <= count_p + 24'd1;
            if (inc_m && count_m != 24'hFFFFFF) count_m <= count_m + 24'd1;
        end
    end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Scoreboard bench: stimulus pushes the expected accumulator pair for every change it causes;
// the monitor pops an entry whenever count_p/count_m move and also checks the strobe pattern.
module tb_gated_pulse_counter;

    logic        clk_12mhz = 1'b0;
    logic        reset = 1'b1;
    logic        cnt_choise = 1'b0;
    logic        count1 = 1'b0, enable1 = 1'b0, count2 = 1'b0, enable2 = 1'b0;
    logic        clk_4mhz;
    logic [23:0] count_p, count_m;

    typedef struct {
        logic [23:0] p;
        logic [23:0] m;
        bit          timed;
        string       name;
    } exp_t;

    exp_t        sb[$];
    bit          done = 1'b0;
    logic [23:0] fin_p = 24'd0, fin_m = 24'd0;
    int          checks = 0, errors = 0;

    gated_pulse_counter dut (
        .clk_12mhz (clk_12mhz),
        .reset     (reset),
        .cnt_choise(cnt_choise),
        .count1    (count1),
        .enable1   (enable1),
        .count2    (count2),
        .enable2   (enable2),
        .clk_4mhz  (clk_4mhz),
        .count_p   (count_p),
        .count_m   (count_m)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_12mhz);
    endtask

    task automatic expect_pair(input logic [23:0] p, input logic [23:0] m, input bit timed, input string name);
        exp_t e;
        e.p = p; e.m = m; e.timed = timed; e.name = name;
        sb.push_back(e);
    endtask

    // One 12-cycle-high / 12-cycle-low pulse on the chosen source.
    task automatic pulse(input bit src, input bit push, input logic [23:0] p, input logic [23:0] m, input string name);
        if (push) expect_pair(p, m, 1'b1, name);
        if (src) count2 = 1'b1; else count1 = 1'b1;
        tick(12);
        if (src) count2 = 1'b0; else count1 = 1'b0;
        tick(12);
    endtask

    // Stimulus
    initial begin
        tick(20);
        reset = 1'b0;
        tick(10);

        // Reset mid-operation, with a pulse that rises during reset and stays high across release.
        enable1 = 1'b1;
        tick(6);
        for (int i = 1; i <= 7; i++) pulse(1'b0, 1'b1, 24'(i), 24'd0, "pre_reset");
        expect_pair(24'd0, 24'd0, 1'b0, "mid_reset_clear");
        expect_pair(24'd1, 24'd0, 1'b1, "straddle_pulse");
        reset = 1'b1;
        count1 = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(12);
        count1 = 1'b0;
        tick(12);
        expect_pair(24'd0, 24'd0, 1'b0, "clean_reset");
        reset = 1'b1;
        tick(20);
        reset = 1'b0;
        tick(6);

        // Gated-high counting on source 1.
        for (int i = 1; i <= 10; i++) pulse(1'b0, 1'b1, 24'(i), 24'd0, "gated_high");

        // Gated-low then gated-high counting on source 2.
        cnt_choise = 1'b1;
        enable2 = 1'b0;
        tick(12);
        for (int i = 1; i <= 5; i++) pulse(1'b1, 1'b1, 24'd10, 24'(i), "gated_low");
        enable2 = 1'b1;
        tick(8);
        for (int i = 1; i <= 3; i++) pulse(1'b1, 1'b1, 24'(10 + i), 24'd5, "gated_high_src2");

        // Source switch with count2 already high: the switch itself must not count.
        cnt_choise = 1'b0;
        tick(12);
        count2 = 1'b1;
        tick(12);
        cnt_choise = 1'b1;
        tick(24);
        count2 = 1'b0;
        tick(12);
        pulse(1'b1, 1'b1, 24'd14, 24'd5, "after_switch");

        // Saturation: preload near the top, then overrun it.
        expect_pair(24'hFFFFFA, 24'd5, 1'b0, "preload");
        force dut.count_p = 24'hFFFFFA;
        tick(1);
        release dut.count_p;
        tick(4);
        for (int i = 1; i <= 8; i++)
            pulse(1'b1, (i <= 5), 24'hFFFFFA + 24'(i), 24'd5, "saturate");

        fin_p = 24'hFFFFFF;
        fin_m = 24'd5;
        tick(4);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic [1:0]  mdiv;
        logic        mclk, r, prev_strobe;
        logic [23:0] last_p, last_m;
        exp_t        e;
        mdiv = 2'd0; mclk = 1'b0; prev_strobe = 1'b0;
        last_p = 24'd0; last_m = 24'd0;
        while (!done) begin
            @(posedge clk_12mhz);
            r = reset;
            @(negedge clk_12mhz);
            if (r) begin
                mdiv = 2'd0;
                mclk = 1'b0;
                checks++;
                if (count_p !== 24'd0 || count_m !== 24'd0) begin
                    errors++;
                    $display("FAIL reset_state: count_p=%0h count_m=%0h required 0 0", count_p, count_m);
                end
            end else begin
                mclk = (mdiv == 2'd2);
                mdiv = (mdiv == 2'd2) ? 2'd0 : mdiv + 2'd1;
            end
            checks++;
            if (clk_4mhz !== mclk) begin
                errors++;
                $display("FAIL strobe @%0t: clk_4mhz=%b required %b", $time, clk_4mhz, mclk);
            end
            if (count_p !== last_p || count_m !== last_m) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change @%0t: count_p=%0h count_m=%0h required %0h %0h",
                             $time, count_p, count_m, last_p, last_m);
                end else begin
                    e = sb.pop_front();
                    if (count_p !== e.p || count_m !== e.m) begin
                        errors++;
                        $display("FAIL %s @%0t: count_p=%0h count_m=%0h required %0h %0h",
                                 e.name, $time, count_p, count_m, e.p, e.m);
                    end
                    if (e.timed) begin
                        checks++;
                        if (!prev_strobe) begin
                            errors++;
                            $display("FAIL %s_timing @%0t: update without preceding strobe, strobe=%b required 1",
                                     e.name, $time, prev_strobe);
                        end
                    end
                end
                last_p = count_p;
                last_m = count_m;
            end
            prev_strobe = clk_4mhz;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d left required 0", sb.size());
        end
        checks++;
        if (count_p !== fin_p || count_m !== fin_m) begin
            errors++;
            $display("FAIL final_counts: count_p=%0h count_m=%0h required %0h %0h", count_p, count_m, fin_p, fin_m);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
